// File: rtl/led_pattern_sequencer.sv
// Running-light controller for the 8-LED display: synchronises and debounces the
// speed switches and mode button, times the step tick and sequences four patterns.
module led_pattern_sequencer #(
  parameter int unsigned     CNT_W      = 32,
  parameter int unsigned     DEB_CYCLES = 500000,
  parameter logic [CNT_W-1:0] PERIOD_DEF = 32'd15000000,
  parameter logic [CNT_W-1:0] PERIOD_SW0 = 32'd30000000,
  parameter logic [CNT_W-1:0] PERIOD_SW1 = 32'd5000000,
  parameter logic [CNT_W-1:0] PERIOD_SW2 = 32'd4000000,
  parameter logic [CNT_W-1:0] PERIOD_SW3 = 32'd3000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] SW,
  input  logic       BTN_N,
  output logic [7:0] LED,
  output logic [1:0] MODE,
  output logic       TICK
);

  localparam int unsigned      DEB_W   = (DEB_CYCLES > 32'd1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 32'd1);
  localparam logic             DIR_LEFT  = 1'b0;
  localparam logic             DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    MODE_SHL    = 2'd0,
    MODE_SHR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_t;

  logic [4:0]       raw_s;
  logic [4:0]       meta_r;
  logic [4:0]       sync_r;
  logic [4:0]       deb_r;
  logic [DEB_W-1:0] deb_cnt_r [5];
  logic             btn_deb_d_r;
  logic             btn_fall_s;
  logic             pending_r;
  logic [CNT_W-1:0] presc_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] presc_nxt_s;
  logic [CNT_W-1:0] period_nxt_s;
  logic [CNT_W-1:0] period_sel_s;
  logic             tick_r;
  mode_t            mode_r;
  mode_t            mode_nxt_s;
  logic [7:0]       led_r;
  logic [7:0]       led_nxt_s;
  logic             dir_r;
  logic             dir_nxt_s;

  function automatic logic [7:0] start_led(input mode_t m);
    case (m)
      MODE_SHL:    start_led = 8'h01;
      MODE_SHR:    start_led = 8'h80;
      MODE_BOUNCE: start_led = 8'h01;
      MODE_FILL:   start_led = 8'h00;
      default:     start_led = 8'h01;
    endcase
  endfunction

  assign raw_s      = {BTN_N, SW};
  assign btn_fall_s = btn_deb_d_r & ~deb_r[4];

  // Two-flop synchronisers, reset to the released (high) level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_r <= 5'h1F;
      sync_r <= 5'h1F;
    end else begin
      meta_r <= raw_s;
      sync_r <= meta_r;
    end
  end

  // Per-input debounce: accept a new level only after DEB_CYCLES mismatching cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deb_r       <= 5'h1F;
      btn_deb_d_r <= 1'b1;
      for (int i = 0; i < 5; i++) begin
        deb_cnt_r[i] <= {DEB_W{1'b0}};
      end
    end else begin
      btn_deb_d_r <= deb_r[4];
      for (int i = 0; i < 5; i++) begin
        if (sync_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= {DEB_W{1'b0}};
        end else if (deb_cnt_r[i] == DEB_MAX) begin
          deb_r[i]     <= sync_r[i];
          deb_cnt_r[i] <= {DEB_W{1'b0}};
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + 1'b1;
        end
      end
    end
  end

  // Step period selection; highest-numbered active (low) switch wins.
  always_comb begin
    period_sel_s = PERIOD_DEF;
    if (!deb_r[3]) begin
      period_sel_s = PERIOD_SW3;
    end else if (!deb_r[2]) begin
      period_sel_s = PERIOD_SW2;
    end else if (!deb_r[1]) begin
      period_sel_s = PERIOD_SW1;
    end else if (!deb_r[0]) begin
      period_sel_s = PERIOD_SW0;
    end else begin
      period_sel_s = PERIOD_DEF;
    end
  end

  // Prescaler next state; the period is relatched only at a tick.
  always_comb begin
    presc_nxt_s  = presc_r + 1'b1;
    period_nxt_s = period_r;
    if (tick_r) begin
      presc_nxt_s  = {CNT_W{1'b0}};
      period_nxt_s = period_sel_s;
    end else begin
      presc_nxt_s  = presc_r + 1'b1;
      period_nxt_s = period_r;
    end
  end

  // TICK is registered from the next-state compare so it marks presc_r >= period_r.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_r  <= {CNT_W{1'b0}};
      period_r <= PERIOD_DEF;
      tick_r   <= 1'b0;
    end else begin
      presc_r  <= presc_nxt_s;
      period_r <= period_nxt_s;
      tick_r   <= (presc_nxt_s >= period_nxt_s);
    end
  end

  // Mode request: a press coinciding with a tick is carried to the following tick.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_r <= 1'b0;
    end else if (tick_r) begin
      pending_r <= btn_fall_s;
    end else if (btn_fall_s) begin
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Pattern sequencer next state; non-one-hot values recover to the mode start.
  always_comb begin
    mode_nxt_s = mode_r;
    led_nxt_s  = led_r;
    dir_nxt_s  = dir_r;
    if (tick_r && pending_r) begin
      mode_nxt_s = mode_t'(mode_r + 2'd1);
      led_nxt_s  = start_led(mode_nxt_s);
      dir_nxt_s  = DIR_LEFT;
    end else if (tick_r) begin
      case (mode_r)
        MODE_SHL: begin
          if (!$onehot(led_r) || (led_r == 8'h80)) begin
            led_nxt_s = 8'h01;
          end else begin
            led_nxt_s = led_r << 1;
          end
        end
        MODE_SHR: begin
          if (!$onehot(led_r) || (led_r == 8'h01)) begin
            led_nxt_s = 8'h80;
          end else begin
            led_nxt_s = led_r >> 1;
          end
        end
        MODE_BOUNCE: begin
          if (!$onehot(led_r)) begin
            led_nxt_s = 8'h01;
            dir_nxt_s = DIR_LEFT;
          end else if (dir_r == DIR_LEFT) begin
            if (led_r == 8'h80) begin
              led_nxt_s = 8'h40;
              dir_nxt_s = DIR_RIGHT;
            end else begin
              led_nxt_s = led_r << 1;
            end
          end else begin
            if (led_r == 8'h01) begin
              led_nxt_s = 8'h02;
              dir_nxt_s = DIR_LEFT;
            end else begin
              led_nxt_s = led_r >> 1;
            end
          end
        end
        MODE_FILL: begin
          if (led_r == 8'hFF) begin
            led_nxt_s = 8'h00;
          end else begin
            led_nxt_s = {led_r[6:0], 1'b1};
          end
        end
        default: begin
          led_nxt_s = 8'h01;
          dir_nxt_s = DIR_LEFT;
        end
      endcase
    end else begin
      mode_nxt_s = mode_r;
      led_nxt_s  = led_r;
      dir_nxt_s  = dir_r;
    end
  end

  // Pattern state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_r <= MODE_SHL;
      led_r  <= 8'h01;
      dir_r  <= DIR_LEFT;
    end else begin
      mode_r <= mode_nxt_s;
      led_r  <= led_nxt_s;
      dir_r  <= dir_nxt_s;
    end
  end

  assign LED  = led_r;
  assign MODE = mode_r;
  assign TICK = tick_r;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: directed and random switch/button stimulus compared every
// cycle against an interval/step-index reference model of the sequencer.
module tb_led_pattern_sequencer;

  localparam int DEB_CYCLES = 4;
  localparam int PERIOD_DEF = 9;
  localparam int PERIOD_SW0 = 19;
  localparam int PERIOD_SW1 = 7;
  localparam int PERIOD_SW2 = 5;
  localparam int PERIOD_SW3 = 3;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] SW    = 4'hF;
  logic       BTN_N = 1'b1;
  logic [7:0] LED;
  logic [1:0] MODE;
  logic       TICK;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  led_pattern_sequencer #(
    .CNT_W      (32),
    .DEB_CYCLES (DEB_CYCLES),
    .PERIOD_DEF (32'd9),
    .PERIOD_SW0 (32'd19),
    .PERIOD_SW1 (32'd7),
    .PERIOD_SW2 (32'd5),
    .PERIOD_SW3 (32'd3)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .SW    (SW),
    .BTN_N (BTN_N),
    .LED   (LED),
    .MODE  (MODE),
    .TICK  (TICK)
  );

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: interval position/length and step index within the current mode.
  logic [4:0] m_deb;
  logic [4:0] m_pipe[$];
  logic [4:0] m_win[$];
  int         m_pos, m_len, m_mode, m_k;
  logic       m_fall, m_pend;

  function automatic int sel_period(input logic [3:0] sw);
    if (!sw[3]) return PERIOD_SW3;
    if (!sw[2]) return PERIOD_SW2;
    if (!sw[1]) return PERIOD_SW1;
    if (!sw[0]) return PERIOD_SW0;
    return PERIOD_DEF;
  endfunction

  function automatic logic [7:0] pat(input int mode, input int k);
    int         p;
    logic [8:0] f;
    case (mode)
      0: pat = 8'h01 << (k % 8);
      1: pat = 8'h80 >> (k % 8);
      2: begin
        p   = k % 14;
        pat = (p < 8) ? (8'h01 << p) : (8'h01 << (14 - p));
      end
      default: begin
        f   = (9'h001 << (k % 9)) - 9'h001;
        pat = f[7:0];
      end
    endcase
  endfunction

  task automatic model_reset();
    m_deb = 5'h1F;
    m_pipe.delete();
    m_pipe.push_back(5'h1F);
    m_pipe.push_back(5'h1F);
    m_win.delete();
    m_pos  = 0;
    m_len  = PERIOD_DEF + 1;
    m_mode = 0;
    m_k    = 0;
    m_fall = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic model_step();
    logic [4:0] sync_b;
    logic       old_btn, same;
    sync_b = m_pipe.pop_front();
    m_pipe.push_back({BTN_N, SW});
    if (m_pos == m_len - 1) begin
      m_pos = 0;
      m_len = sel_period(m_deb[3:0]) + 1;
      if (m_pend) begin
        m_mode = (m_mode + 1) % 4;
        m_k    = 0;
      end else begin
        m_k++;
      end
      m_pend = m_fall;
    end else begin
      m_pos++;
      if (m_fall) m_pend = 1'b1;
    end
    m_win.push_back(sync_b);
    if (m_win.size() > DEB_CYCLES) void'(m_win.pop_front());
    old_btn = m_deb[4];
    if (m_win.size() == DEB_CYCLES) begin
      for (int b = 0; b < 5; b++) begin
        same = 1'b1;
        for (int j = 1; j < DEB_CYCLES; j++) begin
          if (m_win[j][b] != m_win[0][b]) same = 1'b0;
        end
        if (same && (m_win[0][b] != m_deb[b])) m_deb[b] = m_win[0][b];
      end
    end
    m_fall = old_btn & ~m_deb[4];
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) model_reset();
    else        model_step();
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check_value("led",  {24'd0, LED},  {24'd0, pat(m_mode, m_k)});
      check_value("mode", {30'd0, MODE}, m_mode);
      check_value("tick", {31'd0, TICK}, (m_pos == m_len - 1) ? 32'd1 : 32'd0);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input int low_cycles, input int high_cycles);
    BTN_N = 1'b0;
    run(low_cycles);
    BTN_N = 1'b1;
    run(high_cycles);
  endtask

  initial begin
    int edges;
    model_reset();
    run(3);
    chk_en = 1'b1;
    run(2);
    RST_N = 1'b1;

    run(100);                                 // default spacing, SHL sequence
    SW = 4'b0110; run(80);                    // SW3 beats SW0
    SW = 4'hE;    run(120);                   // SW0 alone
    SW = 4'hF;    run(60);
    SW = 4'hD;    run(3);                     // 3-cycle glitch on SW1
    SW = 4'hF;    run(60);

    run(4);
    press(10, 100);                           // to SHR
    SW = 4'hE; run(60);
    press(5, 5); press(5, 60);                // two presses, one interval
    SW = 4'hF; run(190);                      // BOUNCE
    press(10, 110);                           // FILL
    press(10, 40);                            // back to SHL
    for (int i = 0; i < 3; i++) press(8, 25); // back to FILL
    run(15);

    #2 RST_N = 1'b0;
    #1;
    check_value("rst_led",  {24'd0, LED},  32'h01);
    check_value("rst_mode", {30'd0, MODE}, 32'd0);
    check_value("rst_tick", {31'd0, TICK}, 32'd0);
    run(3);
    RST_N = 1'b1;
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      edges++;
      #1;
      if (TICK) break;
    end
    // The release cycle holds prescaler 0, so it counts as the first cycle.
    check_value("rst_tick_cycle", edges + 1, PERIOD_DEF + 1);

    run(1);
    for (int r = 0; r < 70; r++) begin
      SW    = 4'($urandom_range(0, 15));
      BTN_N = 1'($urandom_range(0, 1));
      run($urandom_range(1, 40));
      if (r == 35) begin
        #2 RST_N = 1'b0;
        run(2);
        RST_N = 1'b1;
      end
    end
    SW = 4'hF;
    BTN_N = 1'b1;
    run(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
